debounce_array: RTL and testbench

//  N-channel successor to the single-input debouncer for push-buttons/switches on the board.
//  Per channel: metastability synchroniser, stability counter, debounced level, rise/fall

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 152 +++++++++++++++
 rtl/debounce_array.sv | 52 +++++
 tb/tb_debounce_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and width helpers for the key/switch debounce blocks.
package debounce_pkg;

    typedef enum logic [1:0] {HS_IDLE, HS_PRESSED, HS_REPEAT} hold_state_e;

    // One channel's registered outputs, bundled so the top can fan them out.
    typedef struct packed {
        logic debounced;
        logic pos;
        logic neg;
        logic press;
        logic hold;
        logic rpt;
    } chan_out_t;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int unsigned cnt_width(input longint unsigned max_val);
        return (max_val < 1) ? 1 : int'($clog2(max_val + 1));
    endfunction

    function automatic longint unsigned max2(input longint unsigned a, input longint unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, stability counter, edge strobes
// and the long-press / auto-repeat state machine.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CNT_N       = 65535,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ACTIVE_LVL  = 1'b0,
    parameter bit          RST_LVL     = 1'b1,
    parameter int unsigned HOLD_N      = 50_000_000,
    parameter int unsigned REPEAT_N    = 10_000_000
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_in,
    input  logic      i_repeat_en,
    output chan_out_t o_out
);

    localparam int unsigned CW = cnt_width(CNT_N);
    localparam int unsigned HW = cnt_width(max2(HOLD_N, REPEAT_N));

    localparam logic [CW-1:0] CNT_RELOAD = CW'(CNT_N);
    localparam logic [HW-1:0] HOLD_TGT   = HW'(HOLD_N);
    localparam logic [HW-1:0] REP_TGT    = HW'(REPEAT_N);
    localparam logic [HW-1:0] HCNT_ONE   = HW'(1);
    localparam logic [HW-1:0] HCNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   deb_q, deb_d;
    logic                   pos_q, pos_d;
    logic                   neg_q, neg_d;
    logic                   press_q, press_d;
    logic                   hold_q, hold_d;
    logic                   rpt_q, rpt_d;
    hold_state_e            state_q, state_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;

    logic          s;
    logic          toggle;
    logic          press_ev;
    logic          release_ev;
    logic [HW-1:0] hcnt_inc;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser and stability counter.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_in};
        cnt_d  = CNT_RELOAD;
        deb_d  = deb_q;
        toggle = 1'b0;
        if (s != deb_q) begin
            if (cnt_q == '0) begin
                toggle = 1'b1;
                deb_d  = s;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    assign press_ev   = toggle && (s == ACTIVE_LVL);
    assign release_ev = toggle && (s != ACTIVE_LVL);

    always_comb begin
        pos_d   = toggle & s;
        neg_d   = toggle & ~s;
        press_d = press_ev;
    end

    // Hold / repeat FSM. A release wins over a hold or repeat landing on the same edge.
    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        hold_d   = 1'b0;
        rpt_d    = 1'b0;
        hcnt_inc = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + 1'b1;
        if (release_ev) begin
            state_d = HS_IDLE;
            hcnt_d  = '0;
        end else if (press_ev) begin
            state_d = HS_PRESSED;
            hcnt_d  = HCNT_ONE;
        end else begin
            case (state_q)
                HS_IDLE: begin
                    hcnt_d = '0;
                end
                HS_PRESSED: begin
                    if (hcnt_q == HOLD_TGT) begin
                        hold_d  = 1'b1;
                        rpt_d   = i_repeat_en;
                        state_d = HS_REPEAT;
                        hcnt_d  = HCNT_ONE;
                    end else begin
                        hcnt_d = hcnt_inc;
                    end
                end
                HS_REPEAT: begin
                    if (hcnt_q == REP_TGT) begin
                        rpt_d  = i_repeat_en;
                        hcnt_d = HCNT_ONE;
                    end else begin
                        hcnt_d = hcnt_inc;
                    end
                end
                default: begin
                    state_d = HS_IDLE;
                    hcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= {SYNC_STAGES{RST_LVL}};
            cnt_q   <= CNT_RELOAD;
            deb_q   <= RST_LVL;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
            press_q <= 1'b0;
            hold_q  <= 1'b0;
            rpt_q   <= 1'b0;
            state_q <= HS_IDLE;
            hcnt_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            press_q <= press_d;
            hold_q  <= hold_d;
            rpt_q   <= rpt_d;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        o_out.debounced = deb_q;
        o_out.pos       = pos_q;
        o_out.neg       = neg_q;
        o_out.press     = press_q;
        o_out.hold      = hold_q;
        o_out.rpt       = rpt_q;
    end

endmodule

// File: rtl/debounce_array.sv
// N-channel debouncer for board keys/switches; each channel is an independent
// debounce_channel, outputs gathered into per-signal vectors.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned CNT_N       = 65535,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ACTIVE_LVL  = 1'b0,
    parameter bit          RST_LVL     = 1'b1,
    parameter int unsigned HOLD_N      = 50_000_000,
    parameter int unsigned REPEAT_N    = 10_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N_CH-1:0] i_in,
    input  logic            i_repeat_en,
    output logic [N_CH-1:0] o_debounced,
    output logic [N_CH-1:0] o_pos,
    output logic [N_CH-1:0] o_neg,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_hold,
    output logic [N_CH-1:0] o_repeat
);

    chan_out_t [N_CH-1:0] ch_out;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .CNT_N      (CNT_N),
            .SYNC_STAGES(SYNC_STAGES),
            .ACTIVE_LVL (ACTIVE_LVL),
            .RST_LVL    (RST_LVL),
            .HOLD_N     (HOLD_N),
            .REPEAT_N   (REPEAT_N)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_in       (i_in[g]),
            .i_repeat_en(i_repeat_en),
            .o_out      (ch_out[g])
        );

        assign o_debounced[g] = ch_out[g].debounced;
        assign o_pos[g]       = ch_out[g].pos;
        assign o_neg[g]       = ch_out[g].neg;
        assign o_press[g]     = ch_out[g].press;
        assign o_hold[g]      = ch_out[g].hold;
        assign o_repeat[g]    = ch_out[g].rpt;
    end

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench: a cycle-level reference model predicts each output cycle,
// a monitor compares on the falling edge; directed strobe counts per scenario.
module tb_debounce_array;

    localparam int N_CH     = 4;
    localparam int CNT_N    = 3;
    localparam int SYNC     = 2;
    localparam int HOLD_N   = 20;
    localparam int REPEAT_N = 8;
    localparam bit ACT      = 1'b0;
    localparam bit RSTL     = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic [N_CH-1:0] in  = 4'hF;
    logic            en  = 1'b0;
    logic [N_CH-1:0] deb, pos, neg, press, hold, rpt;

    debounce_array #(
        .N_CH(N_CH), .CNT_N(CNT_N), .SYNC_STAGES(SYNC), .ACTIVE_LVL(ACT),
        .RST_LVL(RSTL), .HOLD_N(HOLD_N), .REPEAT_N(REPEAT_N)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_in(in), .i_repeat_en(en),
        .o_debounced(deb), .o_pos(pos), .o_neg(neg), .o_press(press),
        .o_hold(hold), .o_repeat(rpt)
    );

    typedef struct packed {
        logic [N_CH-1:0] deb, pos, neg, press, hold, rpt;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: raw input delay line, run length of disagreeing samples,
    // and the edge number at which the current press began.
    logic m_dly[N_CH][SYNC];
    logic m_lvl[N_CH];
    int   m_run[N_CH];
    bit   m_held[N_CH];
    int   m_press_edge[N_CH];
    int   m_edge = 0;

    int c_pos[N_CH], c_neg[N_CH], c_press[N_CH], c_hold[N_CH], c_rpt[N_CH];

    task automatic model_step(input logic r, input logic [N_CH-1:0] x, input logic e,
                              output obs_t o);
        o = '0;
        m_edge++;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (r) begin
                for (int k = 0; k < SYNC; k++) m_dly[ch][k] = RSTL;
                m_lvl[ch]  = RSTL;
                m_run[ch]  = 0;
                m_held[ch] = 1'b0;
            end else begin
                logic smp;
                int   d;
                smp = m_dly[ch][SYNC-1];
                for (int k = SYNC-1; k > 0; k--) m_dly[ch][k] = m_dly[ch][k-1];
                m_dly[ch][0] = x[ch];
                m_run[ch] = (smp != m_lvl[ch]) ? m_run[ch] + 1 : 0;
                if (m_run[ch] == CNT_N + 1) begin
                    m_lvl[ch]    = smp;
                    m_run[ch]    = 0;
                    o.pos[ch]    = smp;
                    o.neg[ch]    = !smp;
                    o.press[ch]  = (smp == ACT);
                    m_held[ch]   = (smp == ACT);
                    m_press_edge[ch] = m_edge;
                end else if (m_held[ch]) begin
                    d = m_edge - m_press_edge[ch];
                    if (d == HOLD_N) o.hold[ch] = 1'b1;
                    if (d >= HOLD_N && (d - HOLD_N) % REPEAT_N == 0) o.rpt[ch] = e;
                end
            end
            o.deb[ch] = m_lvl[ch];
        end
    endtask

    task automatic tick(input logic r, input logic [N_CH-1:0] x, input logic e);
        obs_t o;
        rst = r;
        in  = x;
        en  = e;
        @(posedge clk);
        model_step(r, x, e, o);
        exp_q.push_back(o);
        #1;
    endtask

    task automatic ticks(input int n, input logic [N_CH-1:0] x, input logic e);
        for (int i = 0; i < n; i++) tick(1'b0, x, e);
    endtask

    task automatic settle_clear();
        @(negedge clk);
        #1;
        for (int ch = 0; ch < N_CH; ch++) begin
            c_pos[ch] = 0; c_neg[ch] = 0; c_press[ch] = 0; c_hold[ch] = 0; c_rpt[ch] = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{deb, pos, neg, press, hold, rpt};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs @%0t: got deb=%h pos=%h neg=%h press=%h hold=%h rpt=%h, want deb=%h pos=%h neg=%h press=%h hold=%h rpt=%h",
                         $time, a.deb, a.pos, a.neg, a.press, a.hold, a.rpt,
                         e.deb, e.pos, e.neg, e.press, e.hold, e.rpt);
            end
            for (int ch = 0; ch < N_CH; ch++) begin
                c_pos[ch]   += int'(pos[ch]);
                c_neg[ch]   += int'(neg[ch]);
                c_press[ch] += int'(press[ch]);
                c_hold[ch]  += int'(hold[ch]);
                c_rpt[ch]   += int'(rpt[ch]);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N_CH-1:0] x;
        logic            e;
        logic            tog;

        // Reset with all keys idle; nothing may strobe after release.
        tick(1'b1, 4'hF, 1'b0);
        tick(1'b1, 4'hF, 1'b0);
        settle_clear();
        chk("reset_debounced", int'(deb), 15);
        ticks(8, 4'hF, 1'b0);
        settle();
        chk("reset_no_strobes", c_pos[0] + c_neg[0] + c_press[1] + c_hold[2] + c_rpt[3] + c_neg[3], 0);

        // Glitch shorter than the filter is rejected.
        settle_clear();
        ticks(3, 4'hE, 1'b0);
        ticks(12, 4'hF, 1'b0);
        settle();
        chk("glitch3_neg0", c_neg[0], 0);
        chk("glitch3_deb0", int'(deb[0]), 1);

        // Four low samples is exactly enough to fall, then rises back.
        settle_clear();
        ticks(4, 4'hE, 1'b0);
        ticks(12, 4'hF, 1'b0);
        settle();
        chk("glitch4_neg0", c_neg[0], 1);
        chk("glitch4_press0", c_press[0], 1);
        chk("glitch4_pos0", c_pos[0], 1);

        // Long press on ch1 with auto-repeat.
        settle_clear();
        ticks(50, 4'hD, 1'b1);
        ticks(20, 4'hF, 1'b1);
        settle();
        chk("hold_en_hold1", c_hold[1], 1);
        chk("hold_en_rpt1", c_rpt[1], 4);
        chk("hold_en_pos1", c_pos[1], 1);
        chk("hold_en_press1", c_press[1], 1);

        // Same press without repeat enabled.
        settle_clear();
        ticks(50, 4'hD, 1'b0);
        ticks(20, 4'hF, 1'b0);
        settle();
        chk("hold_dis_hold1", c_hold[1], 1);
        chk("hold_dis_rpt1", c_rpt[1], 0);

        // ch2/ch3 switched together while ch0 bounces every cycle.
        settle_clear();
        tog = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, {2'b00, 1'b1, tog}, 1'b0);
            tog = ~tog;
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, {2'b11, 1'b1, tog}, 1'b0);
            tog = ~tog;
        end
        settle();
        chk("indep_press2", c_press[2], 1);
        chk("indep_press3", c_press[3], 1);
        chk("indep_pos3", c_pos[3], 1);
        chk("indep_ch0_quiet", c_neg[0] + c_pos[0], 0);

        // Reset 15 cycles into a press; the key stays low through and after reset.
        settle_clear();
        ticks(6 + 15, 4'hD, 1'b1);
        tick(1'b1, 4'hD, 1'b1);
        ticks(30, 4'hD, 1'b1);
        ticks(12, 4'hF, 1'b1);
        settle();
        chk("midrst_press1", c_press[1], 2);
        chk("midrst_hold1", c_hold[1], 1);
        chk("midrst_pos1", c_pos[1], 1);

        // Random traffic: slow key flips, toggling repeat enable, rare resets.
        x = 4'hF;
        e = 1'b1;
        for (int i = 0; i < 500; i++) begin
            for (int ch = 0; ch < N_CH; ch++)
                if ($urandom_range(0, 9) == 0) x[ch] = ~x[ch];
            if ($urandom_range(0, 15) == 0) e = ~e;
            tick(($urandom_range(0, 199) == 0), x, e);
        end
        ticks(12, 4'hF, e);
        settle();
        settle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
